rom_address_sequencer: RTL and testbench

//  Initiator side of the ROM read path. Walks the parallel ROM chip through addresses 0..LAST_ADDR.

---
 rtl/rom_address_sequencer_pkg.sv | 19 +
 rtl/rom_address_sequencer_timer.sv | 26 ++
 rtl/rom_address_sequencer.sv | 133 +++++++++++++
 tb/tb_rom_address_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_address_sequencer_pkg.sv
// Shared types and defaults for the ROM address sequencer and its access timer.
package rom_address_sequencer_pkg;

  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_LAST_ADDR     = 511;
  localparam int DEF_ACCESS_CYCLES = 4;
  localparam int TIMER_WIDTH       = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/rom_address_sequencer_timer.sv
// rom_access_timer: loadable down-counter that holds at zero; times the ROM output-enable window.
module rom_access_timer
  import rom_address_sequencer_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [TIMER_WIDTH-1:0] i_value,
  output logic                   o_zero
);

  logic [TIMER_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/rom_address_sequencer.sv
// Walks a parallel ROM from address 0 to LAST_ADDR and hands each byte out on valid/ready.
// Optional manual stepping of the address advance: `define ROM_SEQ_SINGLE_STEP_EN.
module rom_address_sequencer
  import rom_address_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LAST_ADDR     = DEF_LAST_ADDR,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
`ifdef ROM_SEQ_SINGLE_STEP_EN
  input  logic                  i_step,
`endif
  output logic [ADDR_WIDTH-1:0] o_address_line,
  output logic                  o_rom_ce_n,
  output logic                  o_rom_oe_n,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output state_t                o_state
);

  // Handshake: a byte moves when o_data_valid & i_data_ready at a rising clk edge;
  // o_data_out is stable while o_data_valid is high and valid never drops without a transfer.

  localparam logic [ADDR_WIDTH-1:0]  LP_LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [TIMER_WIDTH-1:0] LP_WAIT = TIMER_WIDTH'(ACCESS_CYCLES - 1);

  state_t r_state;
  logic   w_timer_load;
  logic   w_timer_zero;
  logic   w_step_ok;

`ifdef ROM_SEQ_SINGLE_STEP_EN
  logic r_step_s1, r_step_s2, r_step_s3;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
    end else begin
      r_step_s1 <= i_step;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  // Edge is only consumed in ADVANCE; elsewhere it simply expires.
  assign w_step_ok = r_step_s2 & ~r_step_s3;
`else
  assign w_step_ok = 1'b1;
`endif

  assign w_timer_load = (r_state == ST_SETUP);

  rom_access_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_load  (w_timer_load),
    .i_value (LP_WAIT),
    .o_zero  (w_timer_zero)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      o_address_line <= '0;
      o_rom_ce_n     <= 1'b1;
      o_rom_oe_n     <= 1'b1;
      o_data_out     <= '0;
      o_data_valid   <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_SETUP;
            o_address_line <= '0;
            o_rom_ce_n     <= 1'b0;
            o_busy         <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          o_rom_oe_n <= 1'b0;
        end
        ST_ACCESS: begin
          if (w_timer_zero) begin
            r_state      <= ST_HOLD;
            o_data_out   <= i_rom_data;
            o_rom_oe_n   <= 1'b1;
            o_data_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_data_ready) begin
            r_state      <= ST_ADVANCE;
            o_data_valid <= 1'b0;
          end
        end
        ST_ADVANCE: begin
          if (w_step_ok) begin
            if (o_address_line == LP_LAST) begin
              r_state <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              r_state        <= ST_SETUP;
              o_address_line <= o_address_line + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          o_rom_ce_n <= 1'b1;
          o_done     <= 1'b0;
          o_busy     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_rom_address_sequencer.sv
// Directed bench for rom_address_sequencer: a full 512-address instance and a single-address instance.
module tb_rom_address_sequencer;
  import rom_address_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start0, ready, ready0, step;
  logic [8:0] addr, addr0;
  logic [7:0] rom_data, rom_data0, data_out, data_out0;
  logic       ce_n, oe_n, valid, busy, done;
  logic       ce_n0, oe_n0, valid0, busy0, done0;
  state_t     st, st0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  assign rom_data  = addr[7:0] ^ 8'h3C;
  assign rom_data0 = 8'hA5;

  rom_address_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .LAST_ADDR(511), .ACCESS_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
`ifdef ROM_SEQ_SINGLE_STEP_EN
    .i_step(step),
`endif
    .o_address_line(addr), .o_rom_ce_n(ce_n), .o_rom_oe_n(oe_n), .i_rom_data(rom_data),
    .o_data_out(data_out), .o_data_valid(valid), .i_data_ready(ready),
    .o_busy(busy), .o_done(done), .o_state(st)
  );

  rom_address_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .LAST_ADDR(0), .ACCESS_CYCLES(4)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(start0),
`ifdef ROM_SEQ_SINGLE_STEP_EN
    .i_step(1'b0),
`endif
    .o_address_line(addr0), .o_rom_ce_n(ce_n0), .o_rom_oe_n(oe_n0), .i_rom_data(rom_data0),
    .o_data_out(data_out0), .o_data_valid(valid0), .i_data_ready(ready0),
    .o_busy(busy0), .o_done(done0), .o_state(st0)
  );

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start0 = 1'b0; ready = 1'b0; ready0 = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({addr, ce_n, oe_n, data_out, valid, busy, done} !== {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs got addr=%0d ce_n=%b oe_n=%b data=%h valid=%b busy=%b done=%b exp 0,1,1,00,0,0,0",
               addr, ce_n, oe_n, data_out, valid, busy, done);
    end
    n_checks++;
    if (st !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", st, ST_IDLE); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({busy, ce_n, oe_n, valid, addr} !== {1'b0, 1'b1, 1'b1, 1'b0, 9'd0}) begin
      n_fail++;
      $display("FAIL idle_no_activity got busy=%b ce_n=%b oe_n=%b valid=%b addr=%0d exp 0,1,1,0,0",
               busy, ce_n, oe_n, valid, addr);
    end
  endtask

  task automatic test_single_byte();
    int k;
    ready0 = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    k = 1;
    while (!valid0 && k < 30) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== 6) begin n_fail++; $display("FAIL single_latency got %0d exp 6", k); end
    n_checks++;
    if (data_out0 !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", data_out0); end
    n_checks++;
    if (addr0 !== 9'd0) begin n_fail++; $display("FAIL single_addr got %0d exp 0", addr0); end
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0) begin n_fail++; $display("FAIL single_accept got valid=%b exp 0", valid0); end
    @(negedge clk);
    n_checks++;
    if ({done0, busy0} !== 2'b11) begin n_fail++; $display("FAIL single_done got done=%b busy=%b exp 1,1", done0, busy0); end
    @(negedge clk);
    n_checks++;
    if ({done0, busy0, ce_n0} !== 3'b001) begin
      n_fail++; $display("FAIL single_idle got done=%b busy=%b ce_n=%b exp 0,0,1", done0, busy0, ce_n0);
    end
    ready0 = 1'b0;
  endtask

  task automatic test_full_sweep();
    int rx, cyc, last_cyc, done_cnt, oe_bad, period_bad;
    logic [7:0] exp_b;
    rx = 0; cyc = 0; last_cyc = 0; done_cnt = 0; oe_bad = 0; period_bad = 0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      logic [8:0] a;
      a = 9'(i);
      exp_q.push_back(a[7:0] ^ 8'h3C);
    end
    ready = 1'b1;
    pulse_start();
    while (cyc < 5000) begin
      if (!oe_n && (valid || ce_n)) oe_bad++;
      if (done) done_cnt++;
      if (valid && ready) begin
        exp_b = exp_q.pop_front();
        n_checks++;
        if (data_out !== exp_b) begin n_fail++; $display("FAIL sweep_data byte %0d got %h exp %h", rx, data_out, exp_b); end
        n_checks++;
        if (addr !== 9'(rx)) begin n_fail++; $display("FAIL sweep_addr byte %0d got %0d exp %0d", rx, addr, rx); end
        if (rx > 0 && (cyc - last_cyc) != 7) period_bad++;
        last_cyc = cyc;
        rx++;
      end
      if (rx == 512 && !busy) break;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rx !== 512) begin n_fail++; $display("FAIL sweep_count got %0d exp 512", rx); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL sweep_done_pulses got %0d exp 1", done_cnt); end
    n_checks++;
    if (oe_bad !== 0) begin n_fail++; $display("FAIL sweep_oe_outside_access got %0d exp 0", oe_bad); end
    n_checks++;
    if (period_bad !== 0) begin n_fail++; $display("FAIL sweep_byte_period got %0d bad exp 0", period_bad); end
    n_checks++;
    if (addr !== 9'd511) begin n_fail++; $display("FAIL sweep_final_addr got %0d exp 511", addr); end
  endtask

  task automatic test_backpressure();
    int k, hold_bad, extra;
    ready = 1'b1;
    pulse_start();
    k = 0;
    while (!(valid && addr == 9'd124) && k < 2000) begin @(negedge clk); k++; end
    ready = 1'b0;
    n_checks++;
    if (!(valid && addr == 9'd124)) begin n_fail++; $display("FAIL bp_reach_124 got addr=%0d valid=%b exp 124,1", addr, valid); end
    hold_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!valid || addr !== 9'd124 || data_out !== (8'd124 ^ 8'h3C) || !oe_n) hold_bad++;
    end
    n_checks++;
    if (hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", hold_bad); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_transfer got valid=%b exp 0", valid); end
    k = 0;
    while (!valid && k < 30) begin @(negedge clk); k++; end
    n_checks++;
    if ({valid, addr, data_out} !== {1'b1, 9'd125, 8'd125 ^ 8'h3C}) begin
      n_fail++; $display("FAIL bp_next_byte got valid=%b addr=%0d data=%h exp 1,125,41", valid, addr, data_out);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (!valid || addr !== 9'd125) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL bp_single_transfer got %0d deviations exp 0", extra); end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    int k;
    ready = 1'b1;
    pulse_start();
    k = 0;
    while (!(addr == 9'd70 && !oe_n) && k < 2000) begin @(negedge clk); k++; end
    n_checks++;
    if (!(addr == 9'd70 && !oe_n)) begin n_fail++; $display("FAIL rmid_reach_70 got addr=%0d oe_n=%b exp 70,0", addr, oe_n); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({addr, ce_n, oe_n, data_out, valid, busy, done} !== {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_async_clear got addr=%0d ce_n=%b oe_n=%b data=%h valid=%b busy=%b done=%b exp 0,1,1,00,0,0,0",
               addr, ce_n, oe_n, data_out, valid, busy, done);
    end
    @(negedge clk); reset = 1'b0;
    pulse_start();
    k = 0;
    while (!valid && k < 30) begin @(negedge clk); k++; end
    n_checks++;
    if ({valid, addr, data_out} !== {1'b1, 9'd0, 8'h3C}) begin
      n_fail++; $display("FAIL rmid_restart got valid=%b addr=%0d data=%h exp 1,0,3c", valid, addr, data_out);
    end
    pulse_reset();
  endtask

`ifdef ROM_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int k, bad;
    ready = 1'b1;
    pulse_start();
    k = 0;
    while (!valid && k < 30) begin @(negedge clk); k++; end
    n_checks++;
    if ({valid, addr, data_out} !== {1'b1, 9'd0, 8'h3C}) begin
      n_fail++; $display("FAIL step_first got valid=%b addr=%0d data=%h exp 1,0,3c", valid, addr, data_out);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid || addr !== 9'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL step_wait got %0d deviations exp 0", bad); end
    for (int i = 1; i <= 3; i++) begin
      logic [8:0] a;
      a = 9'(i);
      @(negedge clk); step = 1'b1;
      repeat (3) @(negedge clk);
      step = 1'b0;
      k = 0;
      while (!valid && k < 30) begin @(negedge clk); k++; end
      n_checks++;
      if ({valid, addr, data_out} !== {1'b1, a, a[7:0] ^ 8'h3C}) begin
        n_fail++; $display("FAIL step_byte %0d got valid=%b addr=%0d data=%h", i, valid, addr, data_out);
      end
      bad = 0;
      repeat (15) begin
        @(negedge clk);
        if (valid || addr !== a) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL step_one_byte %0d got %0d deviations exp 0", i, bad); end
    end
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
`ifdef ROM_SEQ_SINGLE_STEP_EN
    test_single_step();
`else
    test_single_byte();
    test_full_sweep();
    test_backpressure();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
